// File: rtl/pwm_dt_pkg.sv
// pwm_dt_pkg: shared state codes, register offsets and CTRL bit positions for pwm_deadtime
package pwm_dt_pkg;
  typedef enum logic [2:0] {
    OFF     = 3'd0,
    LO_ON   = 3'd1,
    DT_RISE = 3'd2,
    HI_ON   = 3'd3,
    DT_FALL = 3'd4
  } state_e;
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_DT_RISE = 2'd1;
  localparam logic [1:0] REG_DT_FALL = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_POL_HI = 1;
  localparam int CTRL_POL_LO = 2;
endpackage

// File: rtl/dt_down_counter.sv
// dt_down_counter: loadable down counter with zero flag, shared by the rise and fall dead times
//   clk_i, rst_ni : clock, async active-low reset
//   load, load_val: load the count (has priority over dec)
//   dec           : decrement, holds at zero
//   zero          : count is zero
module dt_down_counter #(
  parameter int DTW = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           load,
  input  logic [DTW-1:0] load_val,
  input  logic           dec,
  output logic           zero
);
  logic [DTW-1:0] cnt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: turns a single-ended PWM into a complementary hi/lo pair with independent rise/fall dead times
//   clk_i, rst_ni          : clock, async active-low reset
//   valid_i/ready_o/we_i   : register bus, one-cycle ack
//   addr_i[3:2], wdata_i   : CTRL, DT_RISE, DT_FALL, STATUS
//   rdata_o                : read data during ready_o, else 0
//   pwm_i                  : upstream PWM, same clock domain
//   pwm_hi_o, pwm_lo_o     : registered, polarity-adjusted half-bridge drives
module pwm_deadtime
  import pwm_dt_pkg::*;
#(
  parameter int DTW = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        pwm_i,
  output logic        pwm_hi_o,
  output logic        pwm_lo_o
);
  state_e         state, state_n;
  logic [2:0]     ctrl;
  logic [DTW-1:0] dt_rise, dt_fall, load_val;
  logic           swallow, set_swallow, load, dec, zero, acc, wr;
  logic [1:0]     reg_sel;
  logic [31:0]    rd_mux;
  logic           unused_bits;
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:DTW]};
  assign reg_sel = addr_i[3:2];
  // an access is taken only when not already acking, so a held valid_i acks every other cycle
  assign acc = valid_i && !ready_o;
  assign wr  = acc && we_i;
  always_comb
    rd_mux = reg_sel == REG_CTRL    ? {29'd0, ctrl} :
             reg_sel == REG_DT_RISE ? {{(32-DTW){1'b0}}, dt_rise} :
             reg_sel == REG_DT_FALL ? {{(32-DTW){1'b0}}, dt_fall} :
                                      {28'd0, state, swallow};
  dt_down_counter #(.DTW(DTW)) u_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load    (load),
    .load_val(load_val),
    .dec     (dec),
    .zero    (zero)
  );
  always_comb begin
    state_n     = state;
    load        = 1'b0;
    dec         = 1'b0;
    load_val    = dt_rise - 1'b1;
    set_swallow = 1'b0;
    if (!ctrl[CTRL_EN]) state_n = OFF;
    else
      case (state)
        OFF:     state_n = pwm_i ? HI_ON : LO_ON;
        LO_ON:
          if (pwm_i) begin
            state_n  = dt_rise == '0 ? HI_ON : DT_RISE;
            load     = 1'b1;
            load_val = dt_rise - 1'b1;
          end
        DT_RISE:
          if (!pwm_i) begin
            state_n     = LO_ON;
            set_swallow = 1'b1;
          end else if (zero) state_n = HI_ON;
          else dec = 1'b1;
        HI_ON:
          if (!pwm_i) begin
            state_n  = dt_fall == '0 ? LO_ON : DT_FALL;
            load     = 1'b1;
            load_val = dt_fall - 1'b1;
          end
        DT_FALL:
          if (pwm_i) begin
            state_n     = HI_ON;
            set_swallow = 1'b1;
          end else if (zero) state_n = LO_ON;
          else dec = 1'b1;
        default: state_n = OFF;
      endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state    <= OFF;
      ctrl     <= '0;
      dt_rise  <= '0;
      dt_fall  <= '0;
      swallow  <= 1'b0;
      ready_o  <= 1'b0;
      rdata_o  <= '0;
      pwm_hi_o <= 1'b0;
      pwm_lo_o <= 1'b0;
    end else begin
      state    <= state_n;
      ready_o  <= acc;
      rdata_o  <= acc ? rd_mux : '0;
      if (wr && reg_sel == REG_CTRL) ctrl <= wdata_i[2:0];
      if (wr && reg_sel == REG_DT_RISE) dt_rise <= wdata_i[DTW-1:0];
      if (wr && reg_sel == REG_DT_FALL) dt_fall <= wdata_i[DTW-1:0];
      swallow  <= set_swallow || (swallow && !(wr && reg_sel == REG_STATUS && wdata_i[0]));
      // outputs decode the next state so they change on the same edge as the state flop
      pwm_hi_o <= (state_n == HI_ON) ^ ctrl[CTRL_POL_HI];
      pwm_lo_o <= (state_n == LO_ON) ^ ctrl[CTRL_POL_LO];
    end
endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: randomized and directed checks of pwm_deadtime against a timing-level reference model
module tb_pwm_deadtime;
  logic        clk_i = 1'b0, rst_ni = 1'b0, valid_i = 1'b0, we_i = 1'b0, pwm_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        ready_o, pwm_hi_o, pwm_lo_o;
  logic [31:0] rdata_o;
  int checks = 0, errors = 0;
  always #5 clk_i = ~clk_i;
  pwm_deadtime #(.DTW(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .pwm_i(pwm_i),
    .pwm_hi_o(pwm_hi_o), .pwm_lo_o(pwm_lo_o)
  );
  // model: on = enabled and tracking; side = level being followed; wait = cycles until that side drives
  bit          m_on, m_side, m_sw, m_rdy, m_hi, m_lo, m_phi, m_plo;
  int          m_wait;
  logic [2:0]  m_ctrl;
  logic [7:0]  m_dtr, m_dtf;
  logic [31:0] m_rdata;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] m_code();
    return !m_on ? 3'd0 : m_wait == 0 ? (m_side ? 3'd3 : 3'd1) : (m_side ? 3'd2 : 3'd4);
  endfunction
  task automatic m_reset();
    {m_on, m_side, m_sw, m_rdy, m_hi, m_lo, m_phi, m_plo} = '0;
    m_wait = 0; m_ctrl = '0; m_dtr = '0; m_dtf = '0; m_rdata = '0;
  endtask
  task automatic m_step();
    bit          acc, sw_set;
    logic [1:0]  a;
    logic [31:0] rd;
    acc = valid_i && !m_rdy;
    a = addr_i[3:2];
    sw_set = 1'b0;
    rd = a == 0 ? {29'd0, m_ctrl} : a == 1 ? {24'd0, m_dtr} : a == 2 ? {24'd0, m_dtf} : {28'd0, m_code(), m_sw};
    if (!m_ctrl[0]) m_on = 1'b0;
    else if (!m_on) begin
      m_on = 1'b1; m_side = pwm_i; m_wait = 0;
    end else if (pwm_i != m_side) begin
      if (m_wait > 0) begin
        sw_set = 1'b1; m_wait = 0;
      end else m_wait = pwm_i ? int'(m_dtr) : int'(m_dtf);
      m_side = pwm_i;
    end else if (m_wait > 0) m_wait--;
    m_phi = m_ctrl[1];
    m_plo = m_ctrl[2];
    m_hi = (m_on && m_side && m_wait == 0) ^ m_phi;
    m_lo = (m_on && !m_side && m_wait == 0) ^ m_plo;
    m_sw = sw_set || (m_sw && !(acc && we_i && a == 3 && wdata_i[0]));
    if (acc && we_i && a == 0) m_ctrl = wdata_i[2:0];
    if (acc && we_i && a == 1) m_dtr = wdata_i[7:0];
    if (acc && we_i && a == 2) m_dtf = wdata_i[7:0];
    m_rdata = acc ? rd : '0;
    m_rdy = acc;
  endtask
  task automatic cyc(bit v, bit w, logic [31:0] a, logic [31:0] d, bit p);
    valid_i = v; we_i = w; addr_i = a; wdata_i = d; pwm_i = p;
    m_step();
    @(negedge clk_i);
    check("ready", ready_o, m_rdy);
    check("rdata", rdata_o, m_rdata);
    check("hi", pwm_hi_o, m_hi);
    check("lo", pwm_lo_o, m_lo);
    check("excl", (pwm_hi_o ^ m_phi) & (pwm_lo_o ^ m_plo), 0);
  endtask
  task automatic wr(logic [31:0] a, logic [31:0] d, bit p);
    cyc(1, 1, a, d, p);
    cyc(0, 0, 0, 0, p);
  endtask
  initial begin
    bit          p, v;
    logic [1:0]  a;
    logic [31:0] d;
    m_reset();
    repeat (2) @(negedge clk_i);
    check("rst_ready", ready_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_hi", pwm_hi_o, 0);
    check("rst_lo", pwm_lo_o, 0);
    rst_ni = 1'b1;
    wr(0, 1, 0); wr(4, 3, 0); wr(8, 5, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 1);
      check("t1_rise_lo", pwm_lo_o, 0);
      check("t1_rise_hi", pwm_hi_o, k == 3);
    end
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, 0, 0);
      check("t1_fall_hi", pwm_hi_o, 0);
      check("t1_fall_lo", pwm_lo_o, k == 5);
    end
    wr(4, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("t2_hi", pwm_hi_o, 1);
    check("t2_lo", pwm_lo_o, 0);
    wr(4, 4, 1);
    repeat (6) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("t3_pulse_hi", pwm_hi_o, 0);
    cyc(0, 0, 0, 0, 0);
    check("t3_back_lo", pwm_lo_o, 1);
    cyc(1, 0, 12, 0, 0);
    check("t3_status", rdata_o, 3);
    cyc(0, 0, 0, 0, 0);
    wr(12, 1, 0);
    cyc(1, 0, 12, 0, 0);
    check("t3_status_clr", rdata_o, 2);
    cyc(0, 0, 0, 0, 0);
    wr(0, 7, 0);
    cyc(0, 0, 0, 0, 0);
    check("t4_inv_hi", pwm_hi_o, 1);
    check("t4_inv_lo", pwm_lo_o, 0);
    wr(0, 6, 0);
    cyc(0, 0, 0, 0, 0);
    check("t4_idle_hi", pwm_hi_o, 1);
    check("t4_idle_lo", pwm_lo_o, 1);
    wr(0, 1, 0); wr(4, 4, 0);
    cyc(0, 0, 0, 0, 1);
    wr(0, 0, 1);
    cyc(1, 0, 12, 0, 1);
    check("t5_off", rdata_o, 0);
    cyc(0, 0, 0, 0, 1);
    wr(0, 1, 1);
    check("t5_reen_hi", pwm_hi_o, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 8, 0, 1);
      check("t6_ready", ready_o, k % 2 == 0);
      check("t6_rdata", rdata_o, k % 2 == 0 ? 5 : 0);
    end
    cyc(0, 0, 0, 0, 1);
    wr(0, 7, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 8, 0, 0);
    check("t7_pre_hi", pwm_hi_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("t7_async_hi", pwm_hi_o, 0);
    check("t7_async_lo", pwm_lo_o, 0);
    check("t7_async_ready", ready_o, 0);
    check("t7_async_rdata", rdata_o, 0);
    @(negedge clk_i);
    m_reset();
    rst_ni = 1'b1;
    p = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      v = $urandom_range(0, 3) == 0;
      a = 2'($urandom_range(0, 3));
      if (a == 0) d = {29'd0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) != 0};
      else if (a == 3) d = 32'($urandom_range(0, 1));
      else d = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) p = ~p;
      cyc(v, 1'($urandom_range(0, 1)), {28'd0, a, 2'd0}, d, p);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Per-channel dead-time insertion stage directly downstream of each pwm instance.
- Consumes that instance's single-ended PWM output and drives a complementary high-side/low-side pair for a half-bridge.
- Enforces programmable, independent rise and fall dead times.
- Configured through the same per-channel valid/ready register bus the pwm instances use; pwm_top instantiates one per channel, sharing that channel's address window.

Parameters:
- DTW, 8, width of the dead-time counters and registers (max dead time 2^DTW-1 cycles).

Ports:
- clk_i  in  1  system clock (wb_clk_i).
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  register access request.
- ready_o  out  1  one-cycle access acknowledge.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  32  byte address; only [3:2] decoded.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data, valid while ready_o = 1, else 0.
- pwm_i  in  1  PWM from upstream pwm, same clock domain (no synchroniser).
- pwm_hi_o  out  1  high-side drive.
- pwm_lo_o  out  1  low-side drive.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low on rst_ni.
- Reset values: all registers 0; state OFF; ready_o=0, rdata_o=0, pwm_hi_o=0, pwm_lo_o=0.
- Registers (addr_i[3:2]):
  - 0 CTRL: [0] EN, [1] POL_HI, [2] POL_LO.
  - 1 DT_RISE: [DTW-1:0].
  - 2 DT_FALL: [DTW-1:0].
  - 3 STATUS: [0] SWALLOW (sticky, write-1-clear), [3:1] state code (RO).
  - Reserved bits read 0.
- Bus handshake:
  - ready_o rises the cycle after valid_i is sampled high while ready_o=0, and stays high for exactly one cycle.
  - A held valid_i therefore acks every other cycle.
  - Writes commit on the ready_o cycle.
  - Accesses to any address are acked; no error response.
- FSM states: OFF, LO_ON, DT_RISE, HI_ON, DT_FALL.
- Raw outputs (before polarity):
  - LO_ON: lo=1, hi=0.
  - HI_ON: hi=1, lo=0.
  - OFF, DT_RISE, DT_FALL: both 0.
- Output register: outputs come from flops, glitch-free: pwm_hi_o = raw_hi ^ POL_HI, pwm_lo_o = raw_lo ^ POL_LO.
- Transitions (E0 = first edge sampling the new pwm_i level):
  - EN=0, from any state: go to OFF at next edge. Overrides everything.
  - OFF with EN=1: go to HI_ON if pwm_i=1, else LO_ON. No dead time is applied, because both outputs were already off.
  - LO_ON with pwm_i=1 at E0: lo deasserts at E0.
    - DT_RISE=0: go to HI_ON at E0.
    - Otherwise: go to DT_RISE with cnt=DT_RISE-1.
  - DT_RISE: cnt==0 → HI_ON at next edge; else cnt decrements.
    - Net effect: hi asserts at E0+DT_RISE.
  - HI_ON / DT_FALL: mirror of the two rules above, using DT_FALL; lo asserts at E0+DT_FALL.
- Short pulse:
  - pwm_i returns to 0 while in DT_RISE → go back to LO_ON at that edge and set SWALLOW. hi never asserts.
  - Mirror case: pwm_i returns to 1 in DT_FALL → HI_ON, set SWALLOW.
- DT register write during a count: no effect on the current count; the new value applies at the next load.
- SWALLOW set and W1C in the same cycle: set wins.
- hi and lo raw levels are never simultaneously 1, in any state or sequence.
- Reset mid-count: outputs drop immediately (async); state OFF.

Decomposition:
- Package pwm_dt_pkg:
  - state enum with 3-bit codes OFF=0, LO_ON=1, DT_RISE=2, HI_ON=3, DT_FALL=4;
  - register word offsets;
  - CTRL bit indices.
- Sub-module dt_down_counter (load value, decrement enable, zero flag), parameterised by DTW and shared by both edges.
- Register file and FSM stay in pwm_deadtime.

Test Plan:
- Reset, then write CTRL=1, DT_RISE=3, DT_FALL=5; pwm_i 0→1 at E0 → lo=0 at E0, hi=1 at E0+3; pwm_i 1→0 at E1 → hi=0 at E1, lo=1 at E1+5.
- DT_RISE=0 → lo falls and hi rises on the same edge; hi&lo is never 1 on any cycle.
- DT_RISE=4, pwm_i high for 2 cycles → hi stays 0, lo returns at the falling-edge sample, STATUS reads 0x3 (SWALLOW=1, state LO_ON); write STATUS=1 → reads 0x2.
- CTRL=7 (both polarities inverted), steady pwm_i=0 → pwm_hi_o=1, pwm_lo_o=0; CTRL=6 → both outputs 1 (inactive level).
- Clear EN while in DT_RISE → state OFF next edge, raw outputs 0; set EN with pwm_i=1 → HI_ON immediately.
- Back-to-back valid_i held 4 cycles → ready_o pattern 0,1,0,1; read of DT_FALL=5 returns 0x00000005 only on ready cycles, 0 otherwise; assert rst_ni low mid-count → all outputs 0 asynchronously.
